// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Purpose  : Shared types and constants for the memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int MaxOutstandingMax = 4;
    localparam int PtrW              = 2;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_id_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } arb_state_e;

    // Modulo-depth increment so non-power-of-two depths wrap correctly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr, input int depth);
        if (int'(ptr) >= depth - 1) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface: mem_port_arbiter_if
// Purpose  : Fetch, LSU and unified memory req/gnt/rvalid bundles.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if;

    logic        instr_req_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_o;
    logic [6:0]  instr_rdata_intg_o;
    logic        instr_err_o;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [6:0]  data_wdata_intg_i;
    logic [31:0] data_rdata_o;
    logic [6:0]  data_rdata_intg_o;
    logic        data_err_o;

    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [6:0]  mem_wdata_intg_o;
    logic [31:0] mem_rdata_i;
    logic [6:0]  mem_rdata_intg_i;
    logic        mem_err_i;

    // Arbiter view.
    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_rdata_intg_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, data_wdata_intg_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_wdata_intg_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_rdata_intg_i, mem_err_i
    );

    // Core plus memory view.
    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_rdata_intg_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, data_wdata_intg_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_wdata_intg_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_rdata_intg_i, mem_err_i
    );

endinterface
`default_nettype wire

// File: rtl/arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arb_id_fifo
// Purpose  : In-order owner-ID FIFO for granted, unanswered transactions.
// Revision : 1.0
// ============================================================================
module arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int Depth = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    input  wire logic    push,
    input  wire arb_id_e push_id,
    input  wire logic    pop,
    output arb_id_e      head_id,
    output logic         full,
    output logic         empty,
    output logic [2:0]   count
);

    arb_id_e         entries [MaxOutstandingMax];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [2:0]      occ;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop & (occ != 3'd0);
    // A same-cycle pop frees the slot a push into a full FIFO needs.
    assign do_push = push & ((occ != 3'(Depth)) | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr, Depth);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr, Depth);
            end
            occ <= occ + {2'b00, do_push} - {2'b00, do_pop};
        end
    end

    assign head_id = entries[rd_ptr];
    assign full    = (occ == 3'(Depth));
    assign empty   = (occ == 3'd0);
    assign count   = occ;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between fetch and LSU; in-order response
//            routing. Define ARB_ROUND_ROBIN_EN for round-robin contention.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int   MaxOutstanding = 2,
    parameter logic DataPriority   = 1'b1
) (
    input  wire logic          CLK,
    input  wire logic          RST_N,
    mem_port_arbiter_if.slave  bus,
    output logic [2:0]         outstanding_o,
    output logic               protocol_err_o
);

    arb_state_e state;
    arb_state_e state_next;
    arb_id_e    winner_id;
    arb_id_e    sel_id;
    arb_id_e    head_id;
    logic       any_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       space;
    logic       mem_req;
    logic       grant;
    logic       sel_data;
    logic       prefer_data;
    logic       perr;

    assign any_req = bus.instr_req_i | bus.data_req_i;
    assign pop     = RST_N & bus.mem_rvalid_i & ~fifo_empty;
    assign space   = ~fifo_full | pop;

`ifdef ARB_ROUND_ROBIN_EN
    arb_id_e last_winner;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            last_winner <= ARB_INSTR;
        end else if (grant) begin
            last_winner <= sel_id;
        end
    end

    assign prefer_data = (last_winner == ARB_INSTR);
`else
    assign prefer_data = DataPriority;
`endif

    assign winner_id = (bus.data_req_i & (~bus.instr_req_i | prefer_data)) ? ARB_DATA : ARB_INSTR;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req && space && !bus.mem_gnt_i) begin
                    state_next = (winner_id == ARB_DATA) ? HOLD_D : HOLD_I;
                end
            end
            HOLD_I, HOLD_D: begin
                if (bus.mem_gnt_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A holding state owns the port regardless of the other requester.
    always_comb begin
        sel_id  = winner_id;
        mem_req = 1'b0;
        case (state)
            IDLE:   mem_req = any_req & space;
            HOLD_I: begin
                sel_id  = ARB_INSTR;
                mem_req = 1'b1;
            end
            HOLD_D: begin
                sel_id  = ARB_DATA;
                mem_req = 1'b1;
            end
            default: mem_req = 1'b0;
        endcase
        mem_req = mem_req & RST_N;
    end

    assign grant    = mem_req & bus.mem_gnt_i;
    assign sel_data = (sel_id == ARB_DATA);

    assign bus.mem_req_o        = mem_req;
    assign bus.mem_addr_o       = mem_req ? (sel_data ? bus.data_addr_i : bus.instr_addr_i) : 32'h0;
    assign bus.mem_we_o         = mem_req & sel_data & bus.data_we_i;
    assign bus.mem_be_o         = mem_req ? (sel_data ? bus.data_be_i : 4'hF) : 4'h0;
    assign bus.mem_wdata_o      = (mem_req & sel_data) ? bus.data_wdata_i : 32'h0;
    assign bus.mem_wdata_intg_o = (mem_req & sel_data) ? bus.data_wdata_intg_i : 7'h0;

    assign bus.instr_gnt_o = grant & ~sel_data;
    assign bus.data_gnt_o  = grant & sel_data;

    assign bus.instr_rvalid_o     = pop & (head_id == ARB_INSTR);
    assign bus.data_rvalid_o      = pop & (head_id == ARB_DATA);
    assign bus.instr_rdata_o      = bus.mem_rdata_i;
    assign bus.data_rdata_o       = bus.mem_rdata_i;
    assign bus.instr_rdata_intg_o = bus.mem_rdata_intg_i;
    assign bus.data_rdata_intg_o  = bus.mem_rdata_intg_i;
    assign bus.instr_err_o        = bus.instr_rvalid_o & bus.mem_err_i;
    assign bus.data_err_o         = bus.data_rvalid_o & bus.mem_err_i;

    arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (grant),
        .push_id (sel_id),
        .pop     (pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding_o)
    );

    // Sticky until reset: a response arrived with no owner to route it to.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perr <= 1'b0;
        end else if (bus.mem_rvalid_i && fifo_empty) begin
            perr <= 1'b1;
        end
    end

    assign protocol_err_o = perr;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and randomized bench for mem_port_arbiter with a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int   MaxOut   = 2;
    localparam logic DataPrio = 1'b1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] outstanding;
    logic       perr;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MaxOutstanding (MaxOut),
        .DataPriority   (DataPrio)
    ) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .bus            (bus),
        .outstanding_o  (outstanding),
        .protocol_err_o (perr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner queue, holder (-1 none, 0 instr, 1 data), sticky error.
    int m_q[$];
    int m_lock = -1;
    int m_last = 0;
    bit m_perr = 1'b0;
    bit m_ig   = 1'b0;
    bit m_dg   = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.instr_req_i       = 1'b0;
        bus.instr_addr_i      = 32'h0;
        bus.data_req_i        = 1'b0;
        bus.data_we_i         = 1'b0;
        bus.data_be_i         = 4'h0;
        bus.data_addr_i       = 32'h0;
        bus.data_wdata_i      = 32'h0;
        bus.data_wdata_intg_i = 7'h0;
        bus.mem_gnt_i         = 1'b0;
        bus.mem_rvalid_i      = 1'b0;
        bus.mem_rdata_i       = 32'h0;
        bus.mem_rdata_intg_i  = 7'h0;
        bus.mem_err_i         = 1'b0;
    endtask

    // Compare this cycle's outputs against the model, then advance the model.
    task automatic step();
        bit ireq, dreq, pop, space, pref, exp_req, exp_gnt;
        int sel, owner;
        @(negedge clk);
        check_value("outstanding", 32'(outstanding), 32'(m_q.size()));
        check_value("protocol_err", 32'(perr), 32'(m_perr));
        if (!rst_n) begin
            check_value("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
            check_value("rst_gnt", 32'({bus.instr_gnt_o, bus.data_gnt_o}), 32'h0);
            check_value("rst_rvalid", 32'({bus.instr_rvalid_o, bus.data_rvalid_o}), 32'h0);
            check_value("rst_we_be", 32'({bus.mem_we_o, bus.mem_be_o}), 32'h0);
            m_q.delete();
            m_lock = -1;
            m_last = 0;
            m_perr = 1'b0;
            m_ig   = 1'b0;
            m_dg   = 1'b0;
        end else begin
            ireq  = bus.instr_req_i;
            dreq  = bus.data_req_i;
            pop   = bus.mem_rvalid_i && (m_q.size() > 0);
            space = (m_q.size() < MaxOut) || pop;
`ifdef ARB_ROUND_ROBIN_EN
            pref = (m_last == 0);
`else
            pref = DataPrio;
`endif
            if (m_lock >= 0) begin
                exp_req = 1'b1;
                sel     = m_lock;
            end else if ((ireq || dreq) && space) begin
                exp_req = 1'b1;
                sel     = (dreq && (!ireq || pref)) ? 1 : 0;
            end else begin
                exp_req = 1'b0;
                sel     = 0;
            end
            exp_gnt = exp_req && bus.mem_gnt_i;
            owner   = pop ? m_q[0] : -1;

            check_value("mem_req", 32'(bus.mem_req_o), 32'(exp_req));
            check_value("instr_gnt", 32'(bus.instr_gnt_o), 32'(exp_gnt && sel == 0));
            check_value("data_gnt", 32'(bus.data_gnt_o), 32'(exp_gnt && sel == 1));
            if (exp_req) begin
                check_value("mem_addr", bus.mem_addr_o, (sel == 1) ? bus.data_addr_i : bus.instr_addr_i);
                check_value("mem_we", 32'(bus.mem_we_o), (sel == 1) ? 32'(bus.data_we_i) : 32'h0);
                check_value("mem_be", 32'(bus.mem_be_o), (sel == 1) ? 32'(bus.data_be_i) : 32'hF);
                check_value("mem_wdata", bus.mem_wdata_o, (sel == 1) ? bus.data_wdata_i : 32'h0);
                check_value("mem_wintg", 32'(bus.mem_wdata_intg_o), (sel == 1) ? 32'(bus.data_wdata_intg_i) : 32'h0);
            end
            check_value("instr_rvalid", 32'(bus.instr_rvalid_o), 32'(owner == 0));
            check_value("data_rvalid", 32'(bus.data_rvalid_o), 32'(owner == 1));
            check_value("instr_err", 32'(bus.instr_err_o), 32'(owner == 0 && bus.mem_err_i));
            check_value("data_err", 32'(bus.data_err_o), 32'(owner == 1 && bus.mem_err_i));
            check_value("instr_rdata", bus.instr_rdata_o, bus.mem_rdata_i);
            check_value("data_rdata", bus.data_rdata_o, bus.mem_rdata_i);
            check_value("instr_rintg", 32'(bus.instr_rdata_intg_o), 32'(bus.mem_rdata_intg_i));
            check_value("data_rintg", 32'(bus.data_rdata_intg_o), 32'(bus.mem_rdata_intg_i));

            if (bus.mem_rvalid_i && m_q.size() == 0) m_perr = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (exp_gnt) begin
                m_q.push_back(sel);
                m_last = sel;
            end
            m_lock = exp_gnt ? -1 : (exp_req ? sel : -1);
            m_ig   = exp_gnt && sel == 0;
            m_dg   = exp_gnt && sel == 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Requesters keep their fields stable until granted; memory answers in order.
    task automatic drive_random();
        if (!bus.instr_req_i || m_ig) begin
            bus.instr_req_i  = ($urandom_range(0, 2) != 0);
            bus.instr_addr_i = $urandom() & 32'hFFFF_FFFC;
        end
        if (!bus.data_req_i || m_dg) begin
            bus.data_req_i        = ($urandom_range(0, 2) != 0);
            bus.data_we_i         = 1'($urandom_range(0, 1));
            bus.data_be_i         = 4'($urandom_range(1, 15));
            bus.data_addr_i       = $urandom();
            bus.data_wdata_i      = $urandom();
            bus.data_wdata_intg_i = 7'($urandom_range(0, 127));
        end
        bus.mem_gnt_i        = ($urandom_range(0, 3) != 0);
        bus.mem_rvalid_i     = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
        bus.mem_rdata_i      = $urandom();
        bus.mem_rdata_intg_i = 7'($urandom_range(0, 127));
        bus.mem_err_i        = ($urandom_range(0, 7) == 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        set_idle();
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;
        step();

        // Single fetch with immediate grant, response next cycle.
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0100; bus.mem_gnt_i = 1'b1;
        step();
        bus.instr_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_0013;
        step();
        set_idle();
        step();

        // Contention with a stalled memory: data held for three cycles.
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0200;
        bus.data_req_i = 1'b1; bus.data_addr_i = 32'h8000_0040; bus.data_we_i = 1'b1;
        bus.data_be_i = 4'h3; bus.data_wdata_i = 32'hDEAD_BEEF; bus.data_wdata_intg_i = 7'h55;
        repeat (3) step();
        bus.mem_gnt_i = 1'b1;
        step();
        bus.data_req_i = 1'b0;
        step();
        bus.instr_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
        repeat (2) step();
        set_idle();
        step();

        // Two outstanding, third blocked until the first response frees a slot.
        bus.mem_gnt_i = 1'b1;
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0300;
        step();
        bus.instr_req_i = 1'b0;
        bus.data_req_i = 1'b1; bus.data_addr_i = 32'h8000_0080;
        step();
        bus.data_req_i = 1'b0;
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0304;
        repeat (2) step();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1111_1111;
        step();
        bus.instr_req_i = 1'b0; bus.mem_rdata_i = 32'h2222_2222;
        step();
        bus.mem_rdata_i = 32'h3333_3333;
        step();
        set_idle();
        step();

        // Response with nothing outstanding sets the sticky error; reset clears it.
        bus.mem_rvalid_i = 1'b1;
        step();
        bus.mem_rvalid_i = 1'b0;
        repeat (2) step();
        pulse_reset();
        step();

        // Reset while holding data with one outstanding, then a stale response.
        bus.instr_req_i = 1'b1; bus.mem_gnt_i = 1'b1;
        step();
        bus.instr_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.data_req_i = 1'b1;
        step();
        pulse_reset();
        bus.data_req_i = 1'b0;
        step();
        bus.mem_rvalid_i = 1'b1;
        step();
        bus.mem_rvalid_i = 1'b0;
        step();
        pulse_reset();

        // Continuous contention with immediate grants.
        bus.instr_req_i = 1'b1; bus.data_req_i = 1'b1; bus.mem_gnt_i = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        repeat (8) step();
        set_idle();
        bus.mem_rvalid_i = 1'b1;
        repeat (2) step();
        set_idle();
        step();

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
